// File: rtl/shift_pkg.sv
// Shared encodings for the shift-register command sequencer.
package shift_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'b00,
    LEFT  = 2'b01,
    RIGHT = 2'b10,
    LOAD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/shift_seq.sv
// Command sequencer driving mode selects, parallel word and serial bits
// into a negedge-sampled shift register; every output is a posedge flop.
module shift_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LEN_W = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [LEN_W-1:0]        cmd_len,
  input  logic [WIDTH-1:0]        cmd_data,
  input  logic [(1<<LEN_W)-1:0]   cmd_serial,
  output logic                    select1,
  output logic                    select0,
  output logic [WIDTH-1:0]        p_in,
  output logic                    left_shift_inp,
  output logic                    right_shift_inp,
  output logic                    busy,
  output logic                    done
);

  localparam int SER_W = 1 << LEN_W;

  state_e             r_state, w_state_nxt;
  logic [LEN_W-1:0]   r_remaining, w_remaining_nxt;
  logic [LEN_W-1:0]   r_idx, w_idx_nxt;
  logic [1:0]         r_op;
  logic [SER_W-1:0]   r_serial;
  logic [1:0]         r_sel, w_sel_nxt;
  logic [WIDTH-1:0]   r_p_in, w_p_in_nxt;
  logic               r_left, r_right, r_ready, r_busy, r_done;
  logic               w_bit_nxt;
  logic               w_accept;

  assign w_accept = cmd_valid && r_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and next-output decode; outputs are registered below.
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_idx_nxt       = r_idx;
    w_sel_nxt       = 2'b00;
    w_p_in_nxt      = r_p_in;
    w_bit_nxt       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          case (op_e'(cmd_op))
            LOAD: begin
              w_state_nxt     = RUN;
              w_remaining_nxt = LEN_W'(1);
              w_sel_nxt       = 2'b11;
              w_p_in_nxt      = cmd_data;
            end
            LEFT, RIGHT: begin
              if (cmd_len != '0) begin
                w_state_nxt     = RUN;
                w_remaining_nxt = cmd_len;
                w_idx_nxt       = LEN_W'(1);
                w_sel_nxt       = cmd_op;
                w_bit_nxt       = cmd_serial[0];
              end else begin
                w_state_nxt = DONE;
              end
            end
            default: w_state_nxt = DONE;
          endcase
        end
      end
      RUN: begin
        if (r_remaining <= LEN_W'(1)) begin
          w_state_nxt = DONE;
        end else begin
          w_remaining_nxt = r_remaining - LEN_W'(1);
          w_idx_nxt       = r_idx + LEN_W'(1);
          w_sel_nxt       = r_op;
          w_bit_nxt       = r_serial[r_idx];
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_remaining <= '0;
      r_idx       <= '0;
      r_op        <= '0;
      r_serial    <= '0;
      r_sel       <= 2'b00;
      r_p_in      <= '0;
      r_left      <= 1'b0;
      r_right     <= 1'b0;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op     <= cmd_op;
        r_serial <= cmd_serial;
      end
      r_remaining <= w_remaining_nxt;
      r_idx       <= w_idx_nxt;
      r_sel       <= w_sel_nxt;
      r_p_in      <= w_p_in_nxt;
      r_left      <= (w_sel_nxt == 2'b01) && w_bit_nxt;
      r_right     <= (w_sel_nxt == 2'b10) && w_bit_nxt;
      r_ready     <= (w_state_nxt == IDLE);
      r_busy      <= (w_state_nxt != IDLE);
      r_done      <= (w_state_nxt == DONE);
    end
  end

  assign select1         = r_sel[1];
  assign select0         = r_sel[0];
  assign p_in            = r_p_in;
  assign left_shift_inp  = r_left;
  assign right_shift_inp = r_right;
  assign cmd_ready       = r_ready;
  assign busy            = r_busy;
  assign done            = r_done;

endmodule

// File: tb/tb_shift_seq.sv
// Directed bench for shift_seq with a behavioural downstream shift register.
module tb_shift_seq;
  import shift_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_len;
  logic [3:0] cmd_data;
  logic [7:0] cmd_serial;
  logic       select1, select0;
  logic [3:0] p_in;
  logic       left_shift_inp, right_shift_inp, busy, done;

  int errors = 0;
  int checks = 0;

  logic [3:0] p_out = 4'b0000;

  shift_seq #(.WIDTH(4), .LEN_W(3)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .cmd_serial(cmd_serial), .select1(select1), .select0(select0),
    .p_in(p_in), .left_shift_inp(left_shift_inp),
    .right_shift_inp(right_shift_inp), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Downstream shift register, sampling on the negedge.
  always @(negedge clk) begin
    case ({select1, select0})
      2'b11:   p_out <= p_in;
      2'b01:   p_out <= {p_out[2:0], left_shift_inp};
      2'b10:   p_out <= {right_shift_inp, p_out[3:1]};
      default: p_out <= p_out;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [2:0] len;
    logic [3:0] data;
    logic [7:0] ser;
    int         n;
    logic [1:0] sel;
    logic [3:0] pout;
    logic [3:0] pin;
  } vec_t;

  vec_t vecs[9];

  task automatic do_cmd(input vec_t v, input int id);
    logic exp_l, exp_r;
    @(negedge clk);
    chk($sformatf("v%0d ready_before", id), cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_op     = v.op;
    cmd_len    = v.len;
    cmd_data   = v.data;
    cmd_serial = v.ser;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < v.n; i++) begin
      exp_l = (v.sel == 2'b01) ? v.ser[i] : 1'b0;
      exp_r = (v.sel == 2'b10) ? v.ser[i] : 1'b0;
      chk($sformatf("v%0d sel c%0d", id, i), {select1, select0}, v.sel);
      chk($sformatf("v%0d ctl c%0d", id, i), {busy, cmd_ready, done}, 3'b100);
      chk($sformatf("v%0d ser c%0d", id, i), {left_shift_inp, right_shift_inp}, {exp_l, exp_r});
      if (v.sel == 2'b11) chk($sformatf("v%0d p_in load", id), p_in, v.data);
      @(posedge clk); #1;
    end
    chk($sformatf("v%0d done_cycle", id),
        {select1, select0, done, cmd_ready, busy, left_shift_inp, right_shift_inp},
        7'b0010100);
    @(posedge clk); #1;
    chk($sformatf("v%0d idle_after", id), {done, cmd_ready, busy}, 3'b010);
    chk($sformatf("v%0d p_out", id), p_out, v.pout);
    chk($sformatf("v%0d p_in hold", id), p_in, v.pin);
  endtask

  int n_left, n_load, n_done;

  initial begin
    vecs[0] = '{2'b11, 3'd0, 4'b1010, 8'h00,       1, 2'b11, 4'b1010, 4'b1010};
    vecs[1] = '{2'b11, 3'd0, 4'b0000, 8'h00,       1, 2'b11, 4'b0000, 4'b0000};
    vecs[2] = '{2'b01, 3'd3, 4'b1111, 8'b00000101, 3, 2'b01, 4'b0101, 4'b0000};
    vecs[3] = '{2'b11, 3'd0, 4'b1111, 8'h00,       1, 2'b11, 4'b1111, 4'b1111};
    vecs[4] = '{2'b10, 3'd2, 4'b0000, 8'h00,       2, 2'b10, 4'b0011, 4'b1111};
    vecs[5] = '{2'b10, 3'd0, 4'b0000, 8'hFF,       0, 2'b00, 4'b0011, 4'b1111};
    vecs[6] = '{2'b00, 3'd5, 4'b0101, 8'hFF,       0, 2'b00, 4'b0011, 4'b1111};
    vecs[7] = '{2'b01, 3'd7, 4'b0000, 8'b01110110, 7, 2'b01, 4'b0111, 4'b1111};
    vecs[8] = '{2'b10, 3'd1, 4'b0000, 8'h01,       1, 2'b10, 4'b1011, 4'b1111};

    // Reset with a load command presented: it must be ignored.
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b11; cmd_len = 3'd0;
    cmd_data = 4'b1111; cmd_serial = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; cmd_valid = 1'b0;
    chk("reset outputs",
        {cmd_ready, select1, select0, busy, done, left_shift_inp, right_shift_inp},
        7'b1000000);
    chk("reset p_in", p_in, 4'b0000);
    @(posedge clk); #1;
    chk("reset no accept", {busy, select1, select0, p_in}, 7'b0);

    for (int i = 0; i < 9; i++) do_cmd(vecs[i], i);

    // Back-pressure: valid held through a left shift, then a load follows.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_len = 3'd2; cmd_serial = 8'h03;
    @(posedge clk); #1;
    cmd_op = 2'b11; cmd_data = 4'b0101;
    n_left = 0; n_load = 0; n_done = 0;
    for (int c = 0; c < 12; c++) begin
      if ({select1, select0} == 2'b01) n_left++;
      if ({select1, select0} == 2'b11) begin n_load++; cmd_valid = 1'b0; end
      if (done) n_done++;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    chk("bp left cycles", n_left, 2);
    chk("bp load cycles", n_load, 1);
    chk("bp done pulses", n_done, 2);
    chk("bp p_out", p_out, 4'b0101);

    // Reset during the second cycle of a 5-cycle shift.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_len = 3'd5; cmd_serial = 8'h1F;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("mid first sel", {select1, select0}, 2'b01);
    @(posedge clk); #1;
    chk("mid second sel", {select1, select0}, 2'b01);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid abort ctl", {select1, select0, done, busy, cmd_ready}, 5'b00001);
    chk("mid abort p_in", p_in, 4'b0000);
    n_done = 0;
    for (int c = 0; c < 6; c++) begin
      if (done || select1 || select0) n_done++;
      @(posedge clk); #1;
    end
    chk("mid no done", n_done, 0);
    chk("mid ready", cmd_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
